thread_dispatcher: RTL and testbench

- Downstream stage of the CVT read path. Consumes the 64-bit ready-thread bitmap, the 10-bit base thread ID and the running basic block each time the CVT is read.
- Buffers these vectors in a small FIFO and serialises the set bits into bundles of up to LANES thread IDs for the execution lanes.
- Drops empty bitmaps. The output uses a valid/ready handshake.

---
 rtl/thread_dispatcher.sv | 200 ++++++++++++++++++++
 tb/tb_thread_dispatcher.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/thread_dispatcher.sv
// Buffers CVT ready-thread bitmaps in a small FIFO and serialises set bits into LANES-wide thread ID bundles.
// Optional dispatched-thread counter enabled by defining THREAD_DISPATCHER_STATS_EN.
module thread_dispatcher #(
  parameter int VEC_W      = 64,
  parameter int ID_W       = 10,
  parameter int BB_W       = 5,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VEC_W-1:0]      in_bitmap,
  input  logic [ID_W-1:0]       in_base_id,
  input  logic [BB_W-1:0]       in_bb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*ID_W-1:0] out_tid,
  output logic [LANES-1:0]      out_lane_mask,
  output logic [BB_W-1:0]       out_bb,
  output logic                  out_last,
  output logic                  idle,
  output logic [10:0]           dispatched_count
);

  localparam int IDX_W = $clog2(VEC_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  logic [VEC_W-1:0]      r_fifo_map  [FIFO_DEPTH];
  logic [ID_W-1:0]       r_fifo_base [FIFO_DEPTH];
  logic [BB_W-1:0]       r_fifo_bb   [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  state_t                r_state;
  logic [VEC_W-1:0]      r_work_map;
  logic [ID_W-1:0]       r_work_base;
  logic [BB_W-1:0]       r_work_bb;
  logic                  r_out_valid;
  logic [LANES*ID_W-1:0] r_out_tid;
  logic [LANES-1:0]      r_out_lane_mask;
  logic [BB_W-1:0]       r_out_bb;
  logic                  r_out_last;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_adv;
  logic                  w_done;
  logic [VEC_W-1:0]      w_head_map;
  logic [ID_W-1:0]       w_head_base;
  logic [BB_W-1:0]       w_head_bb;
  logic [VEC_W-1:0]      w_rem_map;
  logic [LANES*ID_W-1:0] w_lane_tid;
  logic [LANES-1:0]      w_lane_mask;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = in_valid && !w_full;
  assign w_head_map  = r_fifo_map[r_rd_ptr];
  assign w_head_base = r_fifo_base[r_rd_ptr];
  assign w_head_bb   = r_fifo_bb[r_rd_ptr];

  // The engine accepts a new head when idle, or in the same cycle the last
  // bundle of the current bitmap is registered so consecutive bitmaps do not bubble.
  assign w_adv  = (r_state == ST_ISSUE) && (!r_out_valid || out_ready);
  assign w_done = w_adv && (w_rem_map == '0);
  assign w_pop  = !w_empty && ((r_state == ST_IDLE) || w_done);

  assign in_ready      = !w_full;
  assign out_valid     = r_out_valid;
  assign out_tid       = r_out_tid;
  assign out_lane_mask = r_out_lane_mask;
  assign out_bb        = r_out_bb;
  assign out_last      = r_out_last;
  assign idle          = w_empty && (r_state == ST_IDLE) && !r_out_valid;

  // Peel off the lowest set bit LANES times; base IDs are VEC_W-aligned so OR replaces an add.
  always_comb begin : extract
    logic [VEC_W-1:0] v_scan;
    logic [IDX_W-1:0] v_idx;
    v_scan      = r_work_map;
    v_idx       = '0;
    w_lane_mask = '0;
    w_lane_tid  = '0;
    for (int k = 0; k < LANES; k++) begin
      v_idx = '0;
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (v_scan[i]) v_idx = IDX_W'(i);
      end
      if (|v_scan) begin
        w_lane_mask[k]              = 1'b1;
        w_lane_tid[k*ID_W +: ID_W]  = r_work_base | ID_W'(v_idx);
      end
      v_scan = v_scan & (v_scan - VEC_W'(1));
    end
    w_rem_map = v_scan;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_map[r_wr_ptr]  <= in_bitmap;
      r_fifo_base[r_wr_ptr] <= in_base_id;
      r_fifo_bb[r_wr_ptr]   <= in_bb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_work_map      <= '0;
      r_work_base     <= '0;
      r_work_bb       <= '0;
      r_out_valid     <= 1'b0;
      r_out_tid       <= '0;
      r_out_lane_mask <= '0;
      r_out_bb        <= '0;
      r_out_last      <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop && (|w_head_map)) begin
            r_work_map  <= w_head_map;
            r_work_base <= w_head_base;
            r_work_bb   <= w_head_bb;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_adv) begin
            r_out_valid     <= 1'b1;
            r_out_tid       <= w_lane_tid;
            r_out_lane_mask <= w_lane_mask;
            r_out_bb        <= r_work_bb;
            r_out_last      <= (w_rem_map == '0);
            r_work_map      <= w_rem_map;
            if (w_rem_map == '0) begin
              if (w_pop && (|w_head_map)) begin
                r_work_map  <= w_head_map;
                r_work_base <= w_head_base;
                r_work_bb   <= w_head_bb;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef THREAD_DISPATCHER_STATS_EN
  logic [10:0] r_disp_cnt;
  logic [3:0]  w_lane_cnt;
  logic [11:0] w_disp_sum;

  always_comb begin
    w_lane_cnt = '0;
    for (int k = 0; k < LANES; k++) w_lane_cnt = w_lane_cnt + 4'(r_out_lane_mask[k]);
    w_disp_sum = {1'b0, r_disp_cnt} + 12'(w_lane_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_disp_cnt <= '0;
    end else if (r_out_valid && out_ready) begin
      r_disp_cnt <= w_disp_sum[11] ? 11'd2047 : w_disp_sum[10:0];
    end
  end

  assign dispatched_count = r_disp_cnt;
`else
  assign dispatched_count = '0;
`endif

endmodule

// File: tb/tb_thread_dispatcher.sv
// Directed bench for thread_dispatcher: latency, zero-drop, backpressure/full FIFO, back-to-back and reset.
module tb_thread_dispatcher;

  localparam int VEC_W = 64;
  localparam int ID_W  = 10;
  localparam int BB_W  = 5;
  localparam int LANES = 4;
  localparam int BW    = 1 + BB_W + LANES + LANES * ID_W;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [VEC_W-1:0]      in_bitmap;
  logic [ID_W-1:0]       in_base_id;
  logic [BB_W-1:0]       in_bb;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*ID_W-1:0] out_tid;
  logic [LANES-1:0]      out_lane_mask;
  logic [BB_W-1:0]       out_bb;
  logic                  out_last;
  logic                  idle;
  logic [10:0]           dispatched_count;

  int n_checks;
  int n_errors;
  logic [BW-1:0] exp_q[$];

  thread_dispatcher dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_bitmap        (in_bitmap),
    .in_base_id       (in_base_id),
    .in_bb            (in_bb),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_tid          (out_tid),
    .out_lane_mask    (out_lane_mask),
    .out_bb           (out_bb),
    .out_last         (out_last),
    .idle             (idle),
    .dispatched_count (dispatched_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*ID_W-1:0] pack4(input int t0, input int t1, input int t2, input int t3);
    logic [ID_W-1:0] a, b, c, d;
    a = ID_W'(t0); b = ID_W'(t1); c = ID_W'(t2); d = ID_W'(t3);
    return {d, c, b, a};
  endfunction

  function automatic logic [BW-1:0] bundle(input logic last, input int bb, input logic [3:0] mask,
                                           input logic [LANES*ID_W-1:0] tids);
    return {last, BB_W'(bb), mask, tids};
  endfunction

  function automatic logic [BW-1:0] observed();
    return {out_last, out_bb, out_lane_mask, out_tid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [VEC_W-1:0] map, input int base, input int bb);
    in_valid   = 1'b1;
    in_bitmap  = map;
    in_base_id = ID_W'(base);
    in_bb      = BB_W'(bb);
    step();
    in_valid   = 1'b0;
  endtask

  task automatic push_chk(input string tag, input logic [VEC_W-1:0] map, input int base, input int bb,
                          input logic exp_ready);
    chk(tag, 64'(in_ready), 64'(exp_ready));
    push(map, base, bb);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
    chk("wait_valid", 64'(out_valid), 64'd1);
  endtask

  // Consumes n bundles on consecutive cycles (out_ready held high) against exp_q.
  task automatic collect(input int n);
    wait_valid(20);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("valid_%0d", k), 64'(out_valid), 64'd1);
      if (exp_q.size() > 0) chk($sformatf("bundle_%0d", k), 64'(observed()), 64'(exp_q.pop_front()));
      step();
    end
  endtask

  initial begin
    int vcnt;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_bitmap  = '0;
    in_base_id = '0;
    in_bb      = '0;
    out_ready  = 1'b1;
    step();
    step();
    rst = 1'b1;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_out_tid", 64'(out_tid), 64'd0);
    chk("rst_stats", 64'(dispatched_count), 64'd0);

    // Two-cycle latency and split of 0xF5 into 4 + 2 lanes.
    push(64'h0000_0000_0000_00F5, 'h040, 3);
    chk("s1_t0_valid", 64'(out_valid), 64'd0);
    step();
    chk("s1_t1_valid", 64'(out_valid), 64'd0);
    step();
    chk("s1_t2_valid", 64'(out_valid), 64'd1);
    chk("s1_b0", 64'(observed()), 64'(bundle(1'b0, 3, 4'b1111, pack4(64, 66, 68, 69))));
    step();
    chk("s1_t3_valid", 64'(out_valid), 64'd1);
    chk("s1_b1", 64'(observed()), 64'(bundle(1'b1, 3, 4'b0011, pack4(70, 71, 0, 0))));
    step();
    chk("s1_t4_valid", 64'(out_valid), 64'd0);
    chk("s1_idle", 64'(idle), 64'd1);
`ifdef THREAD_DISPATCHER_STATS_EN
    chk("s1_stats", 64'(dispatched_count), 64'd6);
`else
    chk("s1_stats", 64'(dispatched_count), 64'd0);
`endif

    // Zero bitmap is dropped; top bit of the last 64-thread group maps to thread 1023.
    push(64'h0, 'h000, 0);
    push(64'h8000_0000_0000_0000, 'h3C0, 7);
    wait_valid(10);
    chk("s2_b0", 64'(observed()), 64'(bundle(1'b1, 7, 4'b0001, pack4(1023, 0, 0, 0))));
    step();
    chk("s2_no_extra", 64'(out_valid), 64'd0);
    step();
    chk("s2_no_extra2", 64'(out_valid), 64'd0);

    // Backpressure: a 5-bit bitmap parks in the engine, then the FIFO fills with 4 more.
    out_ready = 1'b0;
    push(64'h1F, 'h000, 9);
    step();
    step();
    step();
    push_chk("s3_rdy0", 64'h1, 'h040, 1, 1'b1);
    push_chk("s3_rdy1", 64'h1, 'h080, 2, 1'b1);
    push_chk("s3_rdy2", 64'h1, 'h0C0, 3, 1'b1);
    push_chk("s3_rdy3", 64'h1, 'h100, 4, 1'b1);
    push_chk("s3_rdy4", 64'h1, 'h140, 5, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("s3_hold_valid", 64'(out_valid), 64'd1);
      chk("s3_hold_bundle", 64'(observed()), 64'(bundle(1'b0, 9, 4'b1111, pack4(0, 1, 2, 3))));
      chk("s3_hold_full", 64'(in_ready), 64'd0);
      step();
    end
    exp_q.push_back(bundle(1'b0, 9, 4'b1111, pack4(0, 1, 2, 3)));
    exp_q.push_back(bundle(1'b1, 9, 4'b0001, pack4(4, 0, 0, 0)));
    exp_q.push_back(bundle(1'b1, 1, 4'b0001, pack4(64, 0, 0, 0)));
    exp_q.push_back(bundle(1'b1, 2, 4'b0001, pack4(128, 0, 0, 0)));
    exp_q.push_back(bundle(1'b1, 3, 4'b0001, pack4(192, 0, 0, 0)));
    exp_q.push_back(bundle(1'b1, 4, 4'b0001, pack4(256, 0, 0, 0)));
    out_ready = 1'b1;
    collect(6);
    chk("s3_no_5th", 64'(out_valid), 64'd0);
    chk("s3_idle", 64'(idle), 64'd1);

    // Two full bitmaps back to back: 32 consecutive bundles, tids 0..127.
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back(bundle((k == 15) || (k == 31), (k < 16) ? 5 : 6, 4'b1111,
                             pack4(4 * k, 4 * k + 1, 4 * k + 2, 4 * k + 3)));
    end
    push(64'hFFFF_FFFF_FFFF_FFFF, 'h000, 5);
    push(64'hFFFF_FFFF_FFFF_FFFF, 'h040, 6);
    collect(32);
    chk("s4_end", 64'(out_valid), 64'd0);

    // Reset in the middle of a bitmap discards the remaining work.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(bundle(1'b0, 2, 4'b1111, pack4(128 + 4 * k, 129 + 4 * k, 130 + 4 * k, 131 + 4 * k)));
    end
    push(64'hFFFF_FFFF_FFFF_FFFF, 'h080, 2);
    collect(3);
    rst = 1'b0;
    step();
    chk("s5_valid", 64'(out_valid), 64'd0);
    chk("s5_idle", 64'(idle), 64'd1);
    chk("s5_in_ready", 64'(in_ready), 64'd1);
    chk("s5_stats", 64'(dispatched_count), 64'd0);
    rst  = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) vcnt++;
    end
    chk("s5_no_stale", 64'(vcnt), 64'd0);
    chk("s5_idle_after", 64'(idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
